// File: rtl/cond_unit_mt.sv
// cond_unit_mt: per-context NZCV flag banks, ARM condition evaluation and write-enable gating.
// Saturating skipped-instruction counter is built only when COND_SKIP_CNT_EN is defined.
module cond_unit_mt #(
  parameter int NUM_CTX = 2,
  parameter int OUT_REG = 1,
  parameter int CNT_W   = 16,
  localparam int CW     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Flush,
  input  logic             Valid,
  input  logic [CW-1:0]    CtxId,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             CondFail,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0] bank [NUM_CTX];
  logic       hit;
  logic       n, z, c, v, ge, pass;
  logic       go;
  logic [2:0] gated;

  // Out-of-range CtxId matches no bank, so it reads as zero flags and never passes.
  always_comb begin
    Flags = 4'b0000;
    hit   = 1'b0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (CtxId == CW'(i)) begin
        Flags = bank[i];
        hit   = 1'b1;
      end
    end
  end

  always_comb begin
    {n, z, c, v} = Flags;
    ge = (n == v);
    case (Cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~(c & ~z);
      4'b1010: pass = ge;
      4'b1011: pass = ~ge;
      4'b1100: pass = ~z & ge;
      4'b1101: pass = ~(~z & ge);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign CondEx   = pass & hit;
  assign CondFail = Valid & ~CondEx;
  assign go       = Valid & En & ~Flush & CondEx;
  assign gated    = {PCS, RegW, MemW} & {3{Valid & ~Flush & CondEx}};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) bank[i] <= 4'b0000;
    end else if (go) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (CtxId == CW'(i)) begin
          if (FlagW[1]) bank[i][3:2] <= ALUFlags[3:2];
          if (FlagW[0]) bank[i][1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [2:0] en_q;
      // gated is already zero under Flush, so a flush clears even while stalled.
      always_ff @(posedge clk) begin
        if (reset)
          en_q <= 3'b000;
        else if (En | Flush)
          en_q <= gated;
      end
      assign {PCSrc, RegWrite, MemWrite} = en_q;
    end else begin : g_comb
      assign {PCSrc, RegWrite, MemWrite} = gated;
    end
  endgenerate

`ifdef COND_SKIP_CNT_EN
  logic [CNT_W-1:0] skip_q;
  always_ff @(posedge clk) begin
    if (reset)
      skip_q <= '0;
    else if (Valid & En & ~Flush & ~CondEx & ~(&skip_q))
      skip_q <= skip_q + CNT_W'(1);
  end
  assign SkipCount = skip_q;
`else
  assign SkipCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit_mt.sv
// Bench for cond_unit_mt: directed literal checks plus randomized traffic against a flag-bank model.
module tb_cond_unit_mt;

  localparam int NC   = 3;
  localparam int CNTW = 2;
`ifdef COND_SKIP_CNT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [1:0] ctx = 2'd0;
  logic [3:0] cond = 4'd0, alu = 4'd0;
  logic [1:0] fw = 2'd0;
  logic       pcs = 1'b0, regw = 1'b0, memw = 1'b0;

  logic            r_pc, r_rw, r_mw, r_ce, r_cf;
  logic [3:0]      r_fl;
  logic [CNTW-1:0] r_sk;
  logic            c_pc, c_rw, c_mw, c_ce, c_cf;
  logic [3:0]      c_fl;
  logic [CNTW-1:0] c_sk;

  cond_unit_mt #(.NUM_CTX(NC), .OUT_REG(1), .CNT_W(CNTW)) dut_r (
    .clk(clk), .reset(reset), .En(en), .Flush(flush), .Valid(valid), .CtxId(ctx),
    .Cond(cond), .ALUFlags(alu), .FlagW(fw), .PCS(pcs), .RegW(regw), .MemW(memw),
    .PCSrc(r_pc), .RegWrite(r_rw), .MemWrite(r_mw), .CondEx(r_ce), .CondFail(r_cf),
    .Flags(r_fl), .SkipCount(r_sk));

  cond_unit_mt #(.NUM_CTX(NC), .OUT_REG(0), .CNT_W(CNTW)) dut_c (
    .clk(clk), .reset(reset), .En(en), .Flush(flush), .Valid(valid), .CtxId(ctx),
    .Cond(cond), .ALUFlags(alu), .FlagW(fw), .PCS(pcs), .RegW(regw), .MemW(memw),
    .PCSrc(c_pc), .RegWrite(c_rw), .MemWrite(c_mw), .CondEx(c_ce), .CondFail(c_cf),
    .Flags(c_fl), .SkipCount(c_sk));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state: one flag nibble per context, registered enables, skip count.
  logic [3:0] mflag [NC];
  logic [2:0] mreg;
  int         mcnt;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM rule: condition pairs share a base test, odd encodings invert it; NV never passes.
  function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
    bit fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (cc[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    if (cc == 4'hF) return 1'b0;
    return cc[0] ? !base : base;
  endfunction

  function automatic logic [3:0] model_flags();
    if (int'(ctx) < NC) return mflag[ctx];
    return 4'b0000;
  endfunction

  function automatic bit model_ce();
    if (int'(ctx) >= NC) return 1'b0;
    return cond_true(cond, mflag[ctx]);
  endfunction

  always @(posedge clk) begin
    bit ce;
    logic [2:0] g;
    if (reset) begin
      for (int i = 0; i < NC; i++) mflag[i] = 4'b0000;
      mreg = 3'b000;
      mcnt = 0;
    end else begin
      ce = model_ce();
      g  = (valid && !flush && ce) ? {pcs, regw, memw} : 3'b000;
      if (flush) mreg = 3'b000;
      else if (en) mreg = g;
      if (SKIP && valid && en && !flush && !ce && mcnt < (1 << CNTW) - 1) mcnt++;
      if (valid && en && !flush && ce) begin
        if (fw[1]) mflag[ctx][3:2] = alu[3:2];
        if (fw[0]) mflag[ctx][1:0] = alu[1:0];
      end
    end
  end

  always @(negedge clk) begin
    bit ce;
    logic [2:0] g;
    if (chk_on) begin
      ce = model_ce();
      g  = (valid && !flush && ce) ? {pcs, regw, memw} : 3'b000;
      check("flags_r", 8'(r_fl), 8'(model_flags()));
      check("flags_c", 8'(c_fl), 8'(model_flags()));
      check("condex_r", 8'(r_ce), 8'(ce));
      check("condex_c", 8'(c_ce), 8'(ce));
      check("condfail_r", 8'(r_cf), 8'(valid && !ce));
      check("condfail_c", 8'(c_cf), 8'(valid && !ce));
      check("enables_c", 8'({c_pc, c_rw, c_mw}), 8'(g));
      check("enables_r", 8'({r_pc, r_rw, r_mw}), 8'(mreg));
      check("skip_r", 8'(r_sk), 8'(mcnt));
      check("skip_c", 8'(c_sk), 8'(mcnt));
    end
  end

  task automatic drive(input logic v, input logic [1:0] cx, input logic [3:0] cnd,
                       input logic [3:0] a, input logic [1:0] w, input logic p,
                       input logic r, input logic m, input logic e, input logic f);
    @(posedge clk); #1;
    valid = v; ctx = cx; cond = cnd; alu = a; fw = w;
    pcs = p; regw = r; memw = m; en = e; flush = f;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0; en = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("lit_reset_enables", 8'({r_pc, r_rw, r_mw}), 8'h0);
    check("lit_reset_flags", 8'(r_fl), 8'h0);
    check("lit_reset_skip", 8'(r_sk), 8'h0);
    @(posedge clk); #1 reset = 1'b0;

    drive(1, 0, 4'b0000, 4'h0, 2'b00, 1, 1, 1, 1, 0);
    @(negedge clk);
    check("lit_eq_after_reset_condex", 8'(c_ce), 8'h0);
    check("lit_eq_after_reset_condfail", 8'(c_cf), 8'h1);
    check("lit_eq_after_reset_en", 8'({c_pc, c_rw, c_mw}), 8'h0);

    drive(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1, 0);
    drive(1, 0, 4'b0000, 4'h0, 2'b00, 0, 1, 0, 1, 0);
    @(negedge clk);
    check("lit_ctx0_flags", 8'(r_fl), 8'h4);
    check("lit_ctx0_eq", 8'(r_ce), 8'h1);
    check("lit_regwrite_comb", 8'(c_rw), 8'h1);
    check("lit_regwrite_not_yet", 8'(r_rw), 8'h0);
    drive(1, 1, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_regwrite_reg", 8'(r_rw), 8'h1);
    check("lit_ctx1_eq", 8'(r_ce), 8'h0);

    drive(1, 2, 4'b1110, 4'b1011, 2'b10, 0, 0, 0, 1, 0);
    drive(1, 2, 4'b1011, 4'h0, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_partial_flags", 8'(r_fl), 8'h8);
    check("lit_lt", 8'(r_ce), 8'h1);
    drive(1, 2, 4'b1010, 4'h0, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_ge", 8'(r_ce), 8'h0);

    drive(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_memwrite_hold", 8'(r_mw), 8'h1);
    end
    drive(1, 0, 4'b1110, 4'hF, 2'b11, 0, 0, 1, 0, 1);
    drive(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_flush_clears", 8'(r_mw), 8'h0);
    check("lit_flush_no_flag", 8'(r_fl), 8'h4);

    drive(1, 0, 4'b1111, 4'hF, 2'b11, 1, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_nv_condex", 8'(c_ce), 8'h0);
    check("lit_nv_pcsrc", 8'(c_pc), 8'h0);
    drive(1, 3, 4'b1110, 4'hF, 2'b11, 1, 1, 1, 1, 0);
    @(negedge clk);
    check("lit_nv_flags_kept", 8'(r_fl), 8'h0);
    check("lit_badctx_condex", 8'(r_ce), 8'h0);
    drive(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("lit_ctx0_after_nv_badctx", 8'(r_fl), 8'h4);
    check("lit_badctx_no_enable", 8'(r_pc), 8'h0);

    do_reset();
    drive(1, 0, 4'b1111, 4'h0, 2'b00, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("lit_skip_flushed", 8'(r_sk), 8'h0);
    for (int i = 1; i <= 6; i++) begin
      drive(i <= 5, 0, 4'b1111, 4'h0, 2'b00, 0, 0, 0, 1, 0);
      @(negedge clk);
      check("lit_skip_count", 8'(c_sk), SKIP ? 8'((i - 1 > 3) ? 3 : i - 1) : 8'h0);
    end

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      valid = 1'($urandom);
      ctx   = 2'($urandom_range(0, 3));
      cond  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      alu   = 4'($urandom);
      fw    = 2'($urandom);
      pcs   = 1'($urandom);
      regw  = 1'($urandom);
      memw  = 1'($urandom);
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
